// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the
// instruction-fetch port and the data (MEM-stage) port. Only one transaction
// is outstanding at a time. Data normally wins arbitration. A fetch that has
// lost MAX_WAIT arbitration rounds in a row gets priority on the next round.
//
// state | meaning
// IDLE  | no transaction outstanding; ready outputs may grant one request
// BUSY  | mem_req held with latched addr/we/wdata until mem_ack
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic        i_rsp_valid,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,

    output logic [31:0] rsp_rdata,

    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        owner
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          fetch_prio;

    // Byte-offset bits are deliberately dropped; addresses are word indices.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    assign fetch_prio = i_valid && (starve_cnt == MAX_CNT);
    assign d_ready    = (state == IDLE) && d_valid && !fetch_prio;
    assign i_ready    = (state == IDLE) && i_valid && (!d_valid || fetch_prio);

    // Main FSM: accept one request in IDLE, hold it in BUSY, pulse the response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            rsp_rdata   <= '0;
            owner       <= 1'b0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_ready) begin
                        mem_addr  <= d_addr[31:2];
                        mem_we    <= d_we;
                        mem_wdata <= d_wdata;
                        owner     <= 1'b1;
                        mem_req   <= 1'b1;
                        state     <= BUSY;
                    end else if (i_ready) begin
                        mem_addr  <= i_addr[31:2];
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        owner     <= 1'b0;
                        mem_req   <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        state       <= IDLE;
                        i_rsp_valid <= ~owner;
                        d_rsp_valid <= owner;
                        rsp_rdata   <= mem_we ? 32'h0 : mem_rdata;
                    end
                end
            endcase
        end
    end

    // Starvation counter: counts arbitration rounds a pending fetch loses to
    // data. It only advances in IDLE, so it measures lost grants rather than
    // raw cycles, and it holds while another transaction is in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!i_valid || i_ready) begin
            starve_cnt <= '0;
        end else if ((state == IDLE) && (starve_cnt != MAX_CNT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
